// File: rtl/box_cmd_pkg.sv
// Shared constants, state/error encodings and colour helper for the box command receiver.
package box_cmd_pkg;

   localparam logic [7:0] MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CNT   = 3'd1,
      BODY  = 3'd2,
      CSUM  = 3'd3,
      TAIL  = 3'd4,
      DRAIN = 3'd5
   } box_rx_state_t;

   typedef enum logic [2:0] {
      E_NONE  = 3'd0,
      E_MAGIC = 3'd1,
      E_CNT   = 3'd2,
      E_RANGE = 3'd3,
      E_CSUM  = 3'd4,
      E_SHORT = 3'd5,
      E_LONG  = 3'd6
   } box_err_t;

   // Replicate a dep-bit channel (right-aligned in ch) MSB-first and keep the top 8 bits.
   function automatic logic [7:0] expand_color(input logic [7:0] ch, input int dep);
      logic [7:0] res;
      logic [2:0] idx;
      res = '0;
      for (int i = 0; i < 8; i++) begin
         idx = 3'(dep - 1 - (i % dep));
         res = {res[6:0], ch[idx]};
      end
      return res;
   endfunction

endpackage

// File: rtl/box_rec_unpack.sv
// Combinational slicer for one box record: extracts coordinates, expands colour, checks range.
module box_rec_unpack
   import box_cmd_pkg::*;
#(
   parameter int XW        = 11,
   parameter int YW        = 10,
   parameter int C_DEP     = 2,
   parameter int H_ACT     = 1280,
   parameter int V_ACT     = 720,
   parameter int REC_BYTES = 6
) (
   input  logic [REC_BYTES*8-1:0] rec,
   output logic [XW-1:0]          start_x,
   output logic [YW-1:0]          start_y,
   output logic [XW-1:0]          end_x,
   output logic [YW-1:0]          end_y,
   output logic [23:0]            color,
   output logic                   range_ok
);

   localparam int TOP = REC_BYTES*8 - 1;
   localparam int CB  = TOP - 2*XW - 2*YW;
   localparam logic [XW:0] H_LIM = (XW+1)'(H_ACT);
   localparam logic [YW:0] V_LIM = (YW+1)'(V_ACT);

   logic [C_DEP-1:0] ch_r;
   logic [C_DEP-1:0] ch_g;
   logic [C_DEP-1:0] ch_b;

   // Fields sit MSB-first from the top of the record; any pad bits at the bottom are ignored.
   always_comb begin
      start_x = rec[TOP -: XW];
      start_y = rec[TOP-XW -: YW];
      end_x   = rec[TOP-XW-YW -: XW];
      end_y   = rec[TOP-2*XW-YW -: YW];
      ch_r    = rec[CB -: C_DEP];
      ch_g    = rec[CB-C_DEP -: C_DEP];
      ch_b    = rec[CB-2*C_DEP -: C_DEP];
   end

   // Expand each channel to 8 bits and require start <= end < active size on both axes.
   always_comb begin
      color    = {expand_color(8'(ch_r), C_DEP),
                  expand_color(8'(ch_g), C_DEP),
                  expand_color(8'(ch_b), C_DEP)};
      range_ok = (start_x <= end_x) && ({1'b0, end_x} < H_LIM) &&
                 (start_y <= end_y) && ({1'b0, end_y} < V_LIM);
   end

endmodule

// File: rtl/box_cmd_rx.sv
// Box-overlay command receiver: parses UDP RX bytes, stages records, commits a full valid set.
module box_cmd_rx
   import box_cmd_pkg::*;
#(
   parameter  int BOX_NUM = 4,
   parameter  int H_ACT   = 1280,
   parameter  int V_ACT   = 720,
   parameter  int C_DEP   = 2,
   localparam int XW      = $clog2(H_ACT),
   localparam int YW      = $clog2(V_ACT),
   localparam int CW      = $clog2(BOX_NUM+1)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 valid,
   input  logic [7:0]           i_data,
   input  logic                 clear,
   output logic [BOX_NUM*XW-1:0] start_xs,
   output logic [BOX_NUM*YW-1:0] start_ys,
   output logic [BOX_NUM*XW-1:0] end_xs,
   output logic [BOX_NUM*YW-1:0] end_ys,
   output logic [BOX_NUM*24-1:0] colors,
   output logic [BOX_NUM-1:0]   box_en,
   output logic                 updated,
   output logic                 err,
   output logic [2:0]           err_code,
   output logic [7:0]           err_cnt
);

   localparam int REC_BITS  = 2*XW + 2*YW + 3*C_DEP;
   localparam int REC_BYTES = (REC_BITS + 7) / 8;
   localparam int RW        = REC_BYTES * 8;
   localparam int BW        = $clog2(REC_BYTES + 1);
   localparam int SW        = (BOX_NUM > 1) ? $clog2(BOX_NUM) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(REC_BYTES - 1);
   localparam logic [7:0]    BOX_NUM_B = 8'(BOX_NUM);

   box_rx_state_t state;
   box_rx_state_t state_next;
   box_err_t      pending;
   box_err_t      err_val;
   logic          err_fire;
   logic          commit_fire;

   logic [RW-1:0] rec_reg;
   logic [RW-1:0] rec_next;
   logic [BW-1:0] byte_idx;
   logic [CW-1:0] rec_idx;
   logic [CW-1:0] n_reg;
   logic [SW-1:0] slot;
   logic [7:0]    xor_acc;
   logic          last_byte;
   logic          last_rec;

   logic [XW-1:0] u_sx;
   logic [YW-1:0] u_sy;
   logic [XW-1:0] u_ex;
   logic [YW-1:0] u_ey;
   logic [23:0]   u_color;
   logic          u_ok;

   logic [XW-1:0] stage_sx    [BOX_NUM];
   logic [YW-1:0] stage_sy    [BOX_NUM];
   logic [XW-1:0] stage_ex    [BOX_NUM];
   logic [YW-1:0] stage_ey    [BOX_NUM];
   logic [23:0]   stage_color [BOX_NUM];

   assign rec_next  = {rec_reg[RW-9:0], i_data};
   assign last_byte = (byte_idx == LAST_BYTE);
   assign last_rec  = ((rec_idx + CW'(1)) == n_reg);
   assign slot      = rec_idx[SW-1:0];

   // The range check looks at the record including the byte arriving this cycle.
   box_rec_unpack #(
      .XW        (XW),
      .YW        (YW),
      .C_DEP     (C_DEP),
      .H_ACT     (H_ACT),
      .V_ACT     (V_ACT),
      .REC_BYTES (REC_BYTES)
   ) u_unpack (
      .rec      (rec_next),
      .start_x  (u_sx),
      .start_y  (u_sy),
      .end_x    (u_ex),
      .end_y    (u_ey),
      .color    (u_color),
      .range_ok (u_ok)
   );

   // Packet state register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus the single-cycle commit/reject decisions; a pending flag outranks later errors.
   always_comb begin
      state_next  = state;
      err_fire    = 1'b0;
      err_val     = E_NONE;
      commit_fire = 1'b0;
      case (state)
         IDLE: begin
            if (valid) begin
               if (i_data == MAGIC) begin
                  state_next = CNT;
               end else begin
                  err_fire   = 1'b1;
                  err_val    = E_MAGIC;
                  state_next = DRAIN;
               end
            end
         end
         CNT: begin
            if (!valid) begin
               err_fire   = 1'b1;
               err_val    = E_SHORT;
               state_next = IDLE;
            end else if (i_data > BOX_NUM_B) begin
               err_fire   = 1'b1;
               err_val    = E_CNT;
               state_next = DRAIN;
            end else if (i_data == 8'd0) begin
               state_next = CSUM;
            end else begin
               state_next = BODY;
            end
         end
         BODY: begin
            if (!valid) begin
               err_fire   = 1'b1;
               err_val    = (pending != E_NONE) ? pending : E_SHORT;
               state_next = IDLE;
            end else if (last_byte && last_rec) begin
               state_next = CSUM;
            end
         end
         CSUM: begin
            if (!valid) begin
               err_fire   = 1'b1;
               err_val    = (pending != E_NONE) ? pending : E_SHORT;
               state_next = IDLE;
            end else begin
               state_next = TAIL;
            end
         end
         TAIL: begin
            if (valid) begin
               err_fire   = 1'b1;
               err_val    = (pending != E_NONE) ? pending : E_LONG;
               state_next = DRAIN;
            end else if (pending == E_NONE) begin
               commit_fire = 1'b1;
               state_next  = IDLE;
            end else begin
               err_fire   = 1'b1;
               err_val    = pending;
               state_next = IDLE;
            end
         end
         DRAIN: begin
            if (!valid) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Byte datapath: running XOR, record shifter, staging writes and the sticky pending error.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rec_reg  <= '0;
         byte_idx <= '0;
         rec_idx  <= '0;
         n_reg    <= '0;
         xor_acc  <= '0;
         pending  <= E_NONE;
         for (int i = 0; i < BOX_NUM; i++) begin
            stage_sx[i]    <= '0;
            stage_sy[i]    <= '0;
            stage_ex[i]    <= '0;
            stage_ey[i]    <= '0;
            stage_color[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               byte_idx <= '0;
               rec_idx  <= '0;
               pending  <= E_NONE;
               if (valid) begin
                  xor_acc <= i_data;
               end
            end
            CNT: begin
               if (valid) begin
                  xor_acc <= xor_acc ^ i_data;
                  n_reg   <= i_data[CW-1:0];
               end
            end
            BODY: begin
               if (valid) begin
                  xor_acc <= xor_acc ^ i_data;
                  rec_reg <= rec_next;
                  if (last_byte) begin
                     byte_idx <= '0;
                     rec_idx  <= rec_idx + CW'(1);
                     if (u_ok) begin
                        stage_sx[slot]    <= u_sx;
                        stage_sy[slot]    <= u_sy;
                        stage_ex[slot]    <= u_ex;
                        stage_ey[slot]    <= u_ey;
                        stage_color[slot] <= u_color;
                     end else if (pending == E_NONE) begin
                        pending <= E_RANGE;
                     end
                  end else begin
                     byte_idx <= byte_idx + BW'(1);
                  end
               end
            end
            CSUM: begin
               if (valid && (i_data != xor_acc) && (pending == E_NONE)) begin
                  pending <= E_CSUM;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Visible box set, pulses and error bookkeeping; a commit outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         start_xs <= '0;
         start_ys <= '0;
         end_xs   <= '0;
         end_ys   <= '0;
         colors   <= '0;
         box_en   <= '0;
         updated  <= 1'b0;
         err      <= 1'b0;
         err_code <= 3'd0;
         err_cnt  <= 8'd0;
      end else begin
         updated <= commit_fire;
         err     <= err_fire;
         if (err_fire) begin
            err_code <= err_val;
            if (err_cnt != 8'hFF) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end
         if (commit_fire) begin
            for (int i = 0; i < BOX_NUM; i++) begin
               if (i < int'(n_reg)) begin
                  start_xs[i*XW +: XW] <= stage_sx[i];
                  start_ys[i*YW +: YW] <= stage_sy[i];
                  end_xs[i*XW +: XW]   <= stage_ex[i];
                  end_ys[i*YW +: YW]   <= stage_ey[i];
                  colors[i*24 +: 24]   <= stage_color[i];
                  box_en[i]            <= 1'b1;
               end else begin
                  start_xs[i*XW +: XW] <= '0;
                  start_ys[i*YW +: YW] <= '0;
                  end_xs[i*XW +: XW]   <= '0;
                  end_ys[i*YW +: YW]   <= '0;
                  colors[i*24 +: 24]   <= '0;
                  box_en[i]            <= 1'b0;
               end
            end
         end else if (clear) begin
            start_xs <= '0;
            start_ys <= '0;
            end_xs   <= '0;
            end_ys   <= '0;
            colors   <= '0;
            box_en   <= '0;
         end
      end
   end

endmodule
